// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decode in the accept cycle, result registered for the next cycle.
// Two-entry output skid (M, K) with a registered in_ready, so there is no combinational ready path.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        sign;
    logic        f3_shift;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [5:0]  shamt;
    logic [4:0]  zimm;
    fmt_e        dec_fmt;
    logic [31:0] dec_imm32;
    entry_t      dec_entry;

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign sign     = in_instr[31];
    assign f3_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign imm_i = {{20{sign}}, in_instr[31:20]};
    assign imm_s = {{20{sign}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{sign}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{sign}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    // Bit 25 belongs to funct7 on RV32, so it only joins the shift amount on RV64.
    assign shamt = {(XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
    assign zimm  = in_instr[19:15];

    always_comb begin
        dec_fmt = FMT_NONE;
        case (opc)
            OP_LOAD, OP_JALR: dec_fmt = FMT_I;
            OP_IMM:           dec_fmt = f3_shift ? FMT_SHAMT : FMT_I;
            OP_IMM_32:        dec_fmt = (XLEN == 64) ? (f3_shift ? FMT_SHAMT : FMT_I) : FMT_NONE;
            OP_STORE:         dec_fmt = FMT_S;
            OP_BRANCH:        dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
            OP_JAL:           dec_fmt = FMT_J;
            OP_SYSTEM:        dec_fmt = f3[2] ? FMT_ZIMM : FMT_I;
            default:          dec_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        dec_imm32 = '0;
        case (dec_fmt)
            FMT_I:   dec_imm32 = imm_i;
            FMT_S:   dec_imm32 = imm_s;
            FMT_B:   dec_imm32 = imm_b;
            FMT_U:   dec_imm32 = imm_u;
            FMT_J:   dec_imm32 = imm_j;
            default: dec_imm32 = '0;
        endcase
    end

    always_comb begin
        dec_entry.fmt = dec_fmt;
        dec_entry.tag = in_tag;
        if (dec_fmt == FMT_SHAMT) begin
            dec_entry.imm = XLEN'(shamt);
        end else if (dec_fmt == FMT_ZIMM) begin
            dec_entry.imm = XLEN'(zimm);
        end else begin
            dec_entry.imm = XLEN'($signed(dec_imm32));
        end
    end

    logic   m_vld_q, m_vld_d;
    logic   k_vld_q, k_vld_d;
    logic   rdy_q, rdy_d;
    entry_t m_q, m_d;
    entry_t k_q, k_d;
    logic   accept;
    logic   consume;

    assign accept  = in_valid & rdy_q;
    assign consume = m_vld_q & out_ready;

    always_comb begin
        m_vld_d = m_vld_q;
        k_vld_d = k_vld_q;
        m_d     = m_q;
        k_d     = k_q;
        if (flush) begin
            m_vld_d = 1'b0;
            k_vld_d = 1'b0;
        end else if (consume && k_vld_q) begin
            m_d     = k_q;
            m_vld_d = 1'b1;
            k_vld_d = 1'b0;
        end else if (accept && (!m_vld_q || consume)) begin
            m_d     = dec_entry;
            m_vld_d = 1'b1;
        end else if (accept) begin
            k_d     = dec_entry;
            k_vld_d = 1'b1;
        end else if (consume) begin
            m_vld_d = 1'b0;
        end
        rdy_d = !k_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            k_vld_q <= 1'b0;
            rdy_q   <= 1'b1;
            m_q     <= '0;
            k_q     <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            k_vld_q <= k_vld_d;
            rdy_q   <= rdy_d;
            m_q     <= m_d;
            k_q     <= k_d;
        end
    end

    // A K->M move and a new accept can never coincide because in_ready tracks !K.valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(accept && consume && k_vld_q));
            assert (rdy_q == !k_vld_q);
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = m_vld_q;
    assign out_imm   = m_q.imm;
    assign out_fmt   = m_q.fmt;
    assign out_tag   = m_q.tag;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, XLEN-parametrised immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate plus a format code one cycle later. A 2-entry skid buffer lets decode stall without a combinational ready path. Beyond the basic I/S/B/U/J formats, it also produces shift-amount and CSR zimm immediates, and supports RV64.

## Interface
- `XLEN`, 32: immediate width; legal values 32 or 64.
- `TAG_W`, 32: width of the sideband tag (PC, ROB id) carried alongside the instruction.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous pipeline flush; discards all held entries.
- `in_valid` input 1: upstream has an instruction.
- `in_ready` output 1: block can accept; driven straight from a register.
- `in_instr` input 32: raw instruction word.
- `in_tag` input TAG_W: sideband, passed through unchanged.
- `out_valid` output 1: `out_*` holds a result.
- `out_ready` input 1: downstream accepts the result.
- `out_imm` output XLEN: extended immediate.
- `out_fmt` output 3: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- `out_tag` output TAG_W: tag of the instruction currently presented.

## Operation
- Decode is keyed on opcode `instr[6:0]` and, where needed, funct3 `instr[14:12]`:
  - LOAD 0000011, JALR 1100111 -> I.
  - OP_IMM 0010011 with funct3 001/101 -> SHAMT; other funct3 -> I.
  - OP_IMM_32 0011011 -> same rule as OP_IMM when XLEN=64; NONE when XLEN=32.
  - STORE 0100011 -> S.
  - BRANCH 1100011 -> B.
  - LUI 0110111, AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - SYSTEM 1110011 with funct3[2]=1 -> ZIMM; other funct3 -> I (CSR address).
  - Any other opcode -> NONE, imm 0.
- Bit fields follow the RISC-V spec. I/S/B/J are sign-extended from `instr[31]` to XLEN. U is `{instr[31:12], 12'b0}`, sign-extended to XLEN (bit 31 replicates when XLEN=64).
- SHAMT is zero-extended: `instr[24:20]` when XLEN=32, `instr[25:20]` when XLEN=64. Funct7 bits never appear in `out_imm`.
- ZIMM is `instr[19:15]`, zero-extended.
- Storage is a main output register M plus a skid register K, each holding {imm, fmt, tag} and a valid bit.
- Handshake:
  - Input is accepted on `in_valid & in_ready`; output is consumed on `out_valid & out_ready`.
  - `out_valid` = M.valid.
  - `in_ready` = !K.valid, registered.
- Each accepted instruction is decoded in the acceptance cycle and written as follows:
  - M is empty, or M is consumed this cycle with K empty -> write to M.
  - M is held (valid and not consumed) -> write to K.
- When M is consumed and K is valid, K moves to M and K clears. If an input is also accepted in that cycle (impossible, since `in_ready`=0 while K is valid), it is discarded; the implementation asserts this never happens.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- Flush:
  - M.valid and K.valid clear next cycle; `in_ready`=1 next cycle.
  - An input presented in the same cycle as `flush` is dropped.
  - A consume in the same cycle as `flush` still counts downstream.
- Reset (same effect whenever asserted, including mid-transfer): M.valid=0, K.valid=0, `in_ready`=1, `out_imm`=0, `out_fmt`=0, `out_tag`=0. `rst` has priority over `flush` and handshakes.
- Datapath registers only load on a write, so they are otherwise stable. `out_*` must not change while `out_valid & !out_ready`.

## Timing
- Latency: an instruction accepted at edge N is presented at `out_*` after edge N; `out_valid` is high in cycle N+1.
- Throughput: 1 instruction/cycle while `out_ready` is held at 1.
- Stall: with `out_ready`=0, the block absorbs exactly 2 instructions. `in_ready` falls in the cycle after the second acceptance.
- Recovery: when `out_ready` returns to 1, `in_ready` rises one cycle later, once K has drained into M.
- No combinational path from `out_ready` to `in_ready`. The only combinational path is input to the decode logic feeding the register D-inputs.

## Test plan
- Format decode at XLEN=32, each instruction streamed with `out_ready`=1:
  - `0xFFF00093` -> imm `0xFFFFFFFF`, fmt 1.
  - `0xFE000EE3` -> imm `0xFFFFFFFC`, fmt 3.
  - `0x0080006F` -> imm `0x00000008`, fmt 5.
  - `0x123452B7` -> imm `0x12345000`, fmt 4.
  - `0x00112423` (sw) -> imm `0x00000008`, fmt 2.
  - `0x0000000B` -> imm 0, fmt 0.
- Special formats:
  - `0x4030D093` (srai) -> imm 3, fmt 6.
  - `0x3002D073` (csrrwi) -> imm 5, fmt 7.
  - `0x30002073` (csrrs) -> imm `0x300`, fmt 1.
- XLEN=64:
  - `0x800002B7` -> imm `0xFFFFFFFF80000000`.
  - `0x03F0D093` -> imm 63, fmt 6.
  - `0x0010009B` (addiw) -> imm 1, fmt 1.
- Backpressure: hold `out_ready`=0 and offer tags A, B, C back-to-back -> A and B accepted, `in_ready`=0 after B, `out_tag`=A stable. Release `out_ready` -> outputs A, B, C in order, no loss.
- Flush with M and K both full and `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, and the flushed input never appears at the output.
- Reset asserted mid-stall with both entries full -> next cycle all outputs at their reset values. The first instruction after reset appears 1 cycle after acceptance.
